// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : motor_pkg
// Brief    : Direction codes, sequencer state type and duty helpers shared by
//            the motor command sequencer files.
// Revision : 1.0 - initial release
// ============================================================================
package motor_pkg;

    localparam logic [7:0] DIR_BRAKE = 8'h10;
    localparam logic [7:0] DIR_FWD   = 8'h02;
    localparam logic [7:0] DIR_LEFT  = 8'h08;
    localparam logic [7:0] DIR_RIGHT = 8'h20;
    localparam logic [7:0] DIR_BACK  = 8'h80;

    localparam logic [6:0] DUTY_MAX  = 7'd100;

    typedef enum logic [1:0] {
        ST_BRAKED    = 2'd0,
        ST_DRIVE     = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_DEAD      = 2'd3
    } seq_state_t;

    function automatic logic is_move_code(input logic [7:0] code);
        return (code == DIR_FWD) || (code == DIR_LEFT) ||
               (code == DIR_RIGHT) || (code == DIR_BACK);
    endfunction

    function automatic logic is_valid_code(input logic [7:0] code);
        return is_move_code(code) || (code == DIR_BRAKE);
    endfunction

    // Move duty toward goal by at most step, landing exactly on goal.
    function automatic logic [6:0] slew(input logic [6:0] duty,
                                        input logic [6:0] goal,
                                        input logic [6:0] step);
        logic [6:0] diff;
        diff = (duty > goal) ? (duty - goal) : (goal - duty);
        if (diff > step) diff = step;
        return (duty > goal) ? (duty - diff) : (duty + diff);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : ramp_tick_gen
// Brief    : Free-running prescaler; tick is high one cycle in every RAMP_DIV.
// Revision : 1.0 - initial release
// ============================================================================
module ramp_tick_gen #(
    parameter int RAMP_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             CW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule
`default_nettype wire

// File: rtl/motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : motor_cmd_sequencer
// Brief    : Turns validated motion commands into slew-limited duty and
//            direction codes with brake dead-time and a command watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module motor_cmd_sequencer
    import motor_pkg::*;
#(
    parameter int RAMP_DIV = 50000,
    parameter int STEP     = 5,
    parameter int DEAD_CYC = 500000,
    parameter int TIMEOUT  = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_code,
    input  logic [6:0] cmd_speed,
    output logic [7:0] dir_code,
    output logic [6:0] duty_cycle_1,
    output logic [6:0] duty_cycle_2,
    output logic       busy,
    output logic       invalid_cmd,
    output logic       timeout
);

    localparam int            DW       = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam int            WW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] DEAD_LD  = DW'(DEAD_CYC);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [6:0]    STEP_V   = 7'(STEP);

    seq_state_t    state_q, state_d;
    logic [7:0]    cur_dir_q, cur_dir_d;
    logic [7:0]    next_dir_q, next_dir_d;
    logic [6:0]    target_q, target_d;
    logic [6:0]    next_target_q, next_target_d;
    logic [6:0]    duty_q, duty_d;
    logic [7:0]    dir_code_q, dir_code_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          invalid_q, invalid_d;
    logic          timeout_q, timeout_d;

    logic          tick;
    logic          accept;
    logic          code_ok;
    logic          wd_fire;
    logic [6:0]    speed_clamped;
    logic [6:0]    goal;

    ramp_tick_gen #(
        .RAMP_DIV (RAMP_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign cmd_ready = (state_q == ST_BRAKED) || (state_q == ST_DRIVE);

    always_comb begin
        accept        = cmd_valid && cmd_ready;
        code_ok       = is_valid_code(cmd_code);
        speed_clamped = (cmd_speed > DUTY_MAX) ? DUTY_MAX : cmd_speed;
        // An accepted command in the same cycle suppresses the watchdog.
        wd_fire       = (TIMEOUT != 0) && (state_q == ST_DRIVE) && !accept &&
                        (wd_cnt_q == WD_LAST);

        state_d       = state_q;
        cur_dir_d     = cur_dir_q;
        next_dir_d    = next_dir_q;
        target_d      = target_q;
        next_target_d = next_target_q;
        dead_cnt_d    = dead_cnt_q;
        invalid_d     = accept && !code_ok;
        timeout_d     = wd_fire;

        case (state_q)
            ST_BRAKED: begin
                if (accept && is_move_code(cmd_code)) begin
                    cur_dir_d = cmd_code;
                    target_d  = speed_clamped;
                    state_d   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (accept && code_ok) begin
                    if (cmd_code == cur_dir_q) begin
                        target_d = speed_clamped;
                    end else begin
                        next_dir_d    = cmd_code;
                        next_target_d = speed_clamped;
                        state_d       = ST_RAMP_DOWN;
                    end
                end else if (wd_fire) begin
                    next_dir_d    = DIR_BRAKE;
                    next_target_d = '0;
                    state_d       = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (duty_q == '0) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = DEAD_LD;
                end
            end
            ST_DEAD: begin
                if (dead_cnt_q <= DW'(1)) begin
                    if (next_dir_q == DIR_BRAKE) begin
                        state_d = ST_BRAKED;
                    end else begin
                        cur_dir_d = next_dir_q;
                        target_d  = next_target_q;
                        state_d   = ST_DRIVE;
                    end
                end else begin
                    dead_cnt_d = dead_cnt_q - DW'(1);
                end
            end
            default: state_d = ST_BRAKED;
        endcase

        if ((TIMEOUT == 0) || (state_q != ST_DRIVE) || accept || wd_fire)
            wd_cnt_d = '0;
        else
            wd_cnt_d = wd_cnt_q + WW'(1);

        goal = (state_q == ST_DRIVE) ? target_q : 7'd0;
        if ((state_q == ST_DRIVE) || (state_q == ST_RAMP_DOWN))
            duty_d = tick ? slew(duty_q, goal, STEP_V) : duty_q;
        else
            duty_d = '0;

        // Direction output trails the state register by one cycle.
        dir_code_d = ((state_q == ST_DRIVE) || (state_q == ST_RAMP_DOWN)) ?
                     cur_dir_q : DIR_BRAKE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BRAKED;
            cur_dir_q     <= DIR_BRAKE;
            next_dir_q    <= DIR_BRAKE;
            target_q      <= '0;
            next_target_q <= '0;
            duty_q        <= '0;
            dir_code_q    <= DIR_BRAKE;
            dead_cnt_q    <= '0;
            wd_cnt_q      <= '0;
            invalid_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_dir_q     <= cur_dir_d;
            next_dir_q    <= next_dir_d;
            target_q      <= target_d;
            next_target_q <= next_target_d;
            duty_q        <= duty_d;
            dir_code_q    <= dir_code_d;
            dead_cnt_q    <= dead_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            invalid_q     <= invalid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign dir_code     = dir_code_q;
    assign duty_cycle_1 = duty_q;
    assign duty_cycle_2 = duty_q;
    assign busy         = (state_q == ST_RAMP_DOWN) || (state_q == ST_DEAD);
    assign invalid_cmd  = invalid_q;
    assign timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_cmd_sequencer
// Brief    : Directed and randomized checks of motor_cmd_sequencer against an
//            arithmetic model of the slew, dead-time and watchdog rules.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_motor_cmd_sequencer;

    localparam int RAMP_DIV = 4;
    localparam int STEP     = 10;
    localparam int DEAD_CYC = 8;
    localparam int TIMEOUT  = 200;

    localparam logic [7:0] B_BRAKE = 8'h10;
    localparam logic [7:0] B_FWD   = 8'h02;
    localparam logic [7:0] B_LEFT  = 8'h08;
    localparam logic [7:0] B_RIGHT = 8'h20;
    localparam logic [7:0] B_BACK  = 8'h80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_code = 8'h00;
    logic [6:0] cmd_speed = 7'd0;
    logic [7:0] dir_code;
    logic [6:0] duty1;
    logic [6:0] duty2;
    logic       busy;
    logic       invalid_cmd;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    motor_cmd_sequencer #(
        .RAMP_DIV (RAMP_DIV),
        .STEP     (STEP),
        .DEAD_CYC (DEAD_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_code     (cmd_code),
        .cmd_speed    (cmd_speed),
        .dir_code     (dir_code),
        .duty_cycle_1 (duty1),
        .duty_cycle_2 (duty2),
        .busy         (busy),
        .invalid_cmd  (invalid_cmd),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int approach(input int d, input int g);
        if (d < g) return (g - d > STEP) ? d + STEP : g;
        if (d > g) return (d - g > STEP) ? d - STEP : g;
        return d;
    endfunction

    function automatic logic [7:0] rand_move(input logic [7:0] avoid);
        logic [7:0] moves [4];
        logic [7:0] m;
        moves[0] = B_FWD; moves[1] = B_LEFT; moves[2] = B_RIGHT; moves[3] = B_BACK;
        do m = moves[$urandom_range(0, 3)]; while (m == avoid);
        return m;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [7:0] code, input logic [6:0] spd);
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_speed = spd;
        chk("ready_before_accept", cmd_ready, 1);
        @(negedge clk);
        accept_cyc = cyc;
        cmd_valid  = 1'b0;
    endtask

    task automatic ramp_to(input int goal, input logic [7:0] exp_dir,
                           input logic exp_ready, input int start);
        int prev;
        int last_chg;
        int n;
        bit first;
        prev = start; last_chg = cyc; n = 0; first = 1'b1;
        while (n < 200) begin
            chk("duty2_eq_duty1", duty2, duty1);
            if (int'(duty1) != prev) begin
                chk("duty_step", duty1, approach(prev, goal));
                if (!first) chk("tick_spacing", cyc - last_chg, RAMP_DIV);
                first = 1'b0;
                last_chg = cyc;
                prev = int'(duty1);
            end
            if (int'(duty1) == goal) break;
            @(negedge clk);
            n++;
            chk("dir_during_ramp", dir_code, exp_dir);
            chk("ready_during_ramp", cmd_ready, exp_ready);
            chk("busy_during_ramp", busy, !exp_ready);
        end
        chk("ramp_reached", duty1, goal);
    endtask

    task automatic change_dir(input logic [7:0] old_dir, input logic [7:0] new_dir,
                              input int spd, input int cur);
        int n;
        int goal;
        goal = (spd > 100) ? 100 : spd;
        send(new_dir, 7'(spd));
        chk("busy_after_change", busy, 1);
        chk("ready_after_change", cmd_ready, 0);
        ramp_to(0, old_dir, 1'b0, cur);
        n = 0;
        while (dir_code == old_dir && n < 20) begin @(negedge clk); n++; end
        chk("zero_to_brake_latency", n, 2);
        n = 0;
        while (dir_code == B_BRAKE && n < 50) begin
            chk("dead_duty_zero", duty1, 0);
            @(negedge clk);
            n++;
        end
        chk("dead_length", n, DEAD_CYC);
        chk("dir_after_dead", dir_code, new_dir);
        ramp_to(goal, new_dir, 1'b1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [7:0] bad;
        logic [7:0] nd;
        int cur;
        int s;
        int g;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dir", dir_code, B_BRAKE);
        chk("rst_duty", duty1, 0);
        chk("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_invalid", invalid_cmd, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_duty2", duty2, 0);

        // Forward at 35: 0 -> 10 -> 20 -> 30 -> 35
        send(B_FWD, 7'd35);
        chk("dir_lags_accept", dir_code, B_BRAKE);
        ramp_to(35, B_FWD, 1'b1, 0);
        send(B_FWD, 7'd40);
        ramp_to(40, B_FWD, 1'b1, 35);

        // Direction change with ramp-down and dead time
        change_dir(B_FWD, B_BACK, 20, 40);

        // Invalid codes leave everything untouched
        send(8'h03, 7'd90);
        chk("invalid_pulse", invalid_cmd, 1);
        chk("invalid_dir", dir_code, B_BACK);
        chk("invalid_duty", duty1, 20);
        @(negedge clk);
        chk("invalid_pulse_end", invalid_cmd, 0);
        do bad = 8'($urandom_range(0, 255));
        while (bad inside {B_BRAKE, B_FWD, B_LEFT, B_RIGHT, B_BACK});
        send(bad, 7'($urandom_range(0, 127)));
        chk("rand_invalid_pulse", invalid_cmd, 1);
        repeat (RAMP_DIV + 1) @(negedge clk);
        chk("rand_invalid_dir", dir_code, B_BACK);
        chk("rand_invalid_duty", duty1, 20);
        chk("rand_invalid_ready", cmd_ready, 1);

        // Watchdog: idle DRIVE at 50 brakes the robot
        send(B_BACK, 7'd50);
        ramp_to(50, B_BACK, 1'b1, 20);
        n = 0;
        while (timeout !== 1'b1 && n < TIMEOUT + 20) begin @(negedge clk); n++; end
        chk("timeout_seen", timeout, 1);
        chk("timeout_latency", cyc - accept_cyc, TIMEOUT);
        @(negedge clk);
        chk("timeout_pulse_end", timeout, 0);
        ramp_to(0, B_BACK, 1'b0, 50);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("brake_dead_length", n, DEAD_CYC + 1);
        @(negedge clk);
        chk("braked_dir", dir_code, B_BRAKE);
        chk("braked_busy", busy, 0);
        chk("braked_duty", duty1, 0);

        // Saturation at 100, then same-direction slew down with no dead phase
        send(B_FWD, 7'd127);
        ramp_to(100, B_FWD, 1'b1, 0);
        send(B_FWD, 7'd60);
        ramp_to(60, B_FWD, 1'b1, 100);
        cur = 60;
        for (int i = 0; i < 4; i++) begin
            s = $urandom_range(0, 127);
            g = (s > 100) ? 100 : s;
            send(B_FWD, 7'(s));
            ramp_to(g, B_FWD, 1'b1, cur);
            cur = g;
        end
        nd = rand_move(B_FWD);
        s  = $urandom_range(1, 127);
        change_dir(B_FWD, nd, s, cur);
        cur = (s > 100) ? 100 : s;

        // Reset in the middle of the dead time
        send(B_FWD, 7'(cur == 0 ? 1 : 30));
        ramp_to(0, nd, 1'b0, cur);
        n = 0;
        while (dir_code != B_BRAKE && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_dir", dir_code, B_BRAKE);
        chk("midreset_duty1", duty1, 0);
        chk("midreset_duty2", duty2, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_ready", cmd_ready, 1);
        repeat (2) begin
            @(negedge clk);
            chk("midreset_no_timeout", timeout, 0);
            chk("midreset_no_invalid", invalid_cmd, 0);
        end
        rst_n = 1'b1;
        s = $urandom_range(1, 100);
        send(B_FWD, 7'(s));
        chk("post_reset_dir_lag", dir_code, B_BRAKE);
        ramp_to(s, B_FWD, 1'b1, 0);
        chk("post_reset_dir", dir_code, B_FWD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
